// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// Owner encoding, requester IDs and default SDRAM geometry.
package sdram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    localparam logic ID_VIDEO = 1'b0;
    localparam logic ID_CPU   = 1'b1;

    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 16;

endpackage

// File: rtl/sdram_port_arbiter_rd_id_fifo.sv
// Read-ID FIFO: remembers which requester issued each outstanding read.
// One bit per entry, pointers wrap naturally on a power-of-two depth.
module rd_id_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     push_id,
    input  logic                     pop,
    output logic                     head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester Avalon-MM arbiter in front of the SDRAM controller port.
// Video fetch (m0) is preferred, bounded by a streak limit when the CPU waits.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = SDRAM_ADDR_W,
    parameter int DATA_W          = SDRAM_DATA_W,
    parameter int MAX_OUTSTANDING = 8,
    parameter int M0_STREAK_MAX   = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [1:0]        m1_byteenable,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [1:0]        s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic              err_orphan
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SW = $clog2(M0_STREAK_MAX + 1);

    owner_t          state;
    logic [SW-1:0]   streak;
    logic [SW-1:0]   streak_inc;
    logic            m1_req;
    logic            owner_req;
    logic            fwd_read;
    logic            block_read;
    logic            accept;
    logic            push;
    logic            push_id;
    logic            fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    assign m1_req     = m1_read | m1_write;
    assign streak_inc = (streak == SW'(M0_STREAK_MAX)) ? streak : streak + SW'(1);

    always_comb begin
        fwd_read       = 1'b0;
        owner_req      = 1'b0;
        s_write        = 1'b0;
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = 2'b00;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (state)
            OWN0: begin
                fwd_read     = m0_read;
                owner_req    = m0_read;
                s_address    = m0_address;
                s_byteenable = 2'b11;
            end
            OWN1: begin
                fwd_read     = m1_read;
                owner_req    = m1_req;
                s_write      = m1_write;
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
            end
            default: ;
        endcase
        // A read with every ID slot taken must wait; writes carry no ID.
        block_read = fwd_read & (fifo_count == CW'(MAX_OUTSTANDING));
        s_read     = fwd_read & ~block_read;
        accept     = owner_req & ~s_waitrequest & ~block_read;
        if (state == OWN0) m0_waitrequest = s_waitrequest | block_read;
        if (state == OWN1) m1_waitrequest = s_waitrequest | block_read;
    end

    assign push    = accept & fwd_read & ~fifo_full;
    assign push_id = (state == OWN1) ? ID_CPU : ID_VIDEO;

    assign rd_data          = s_readdata;
    assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & (fifo_head == ID_VIDEO);
    assign m1_readdatavalid = s_readdatavalid & ~fifo_empty & (fifo_head == ID_CPU);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            streak     <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (s_readdatavalid && fifo_empty) err_orphan <= 1'b1;
            unique case (state)
                IDLE: begin
                    streak <= '0;
                    if (m0_read)     state <= OWN0;
                    else if (m1_req) state <= OWN1;
                end
                OWN0: begin
                    if (!m0_read) begin
                        state  <= m1_req ? OWN1 : IDLE;
                        streak <= '0;
                    end else if (accept) begin
                        if (m1_req && streak_inc >= SW'(M0_STREAK_MAX)) begin
                            state  <= OWN1;
                            streak <= '0;
                        end else begin
                            streak <= streak_inc;
                        end
                    end
                end
                OWN1: begin
                    if (!m1_req) begin
                        state  <= m0_read ? OWN0 : IDLE;
                        streak <= '0;
                    end else if (accept && m0_read) begin
                        state  <= OWN0;
                        streak <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rd_id_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (push),
        .push_id (push_id),
        .pop     (s_readdatavalid),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grant, streak, routing, stall,
// full ID FIFO, orphan detection and asynchronous reset.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] m0_address;
    logic        m0_read;
    logic        m0_waitrequest;
    logic        m0_readdatavalid;
    logic [23:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [15:0] m1_writedata;
    logic [1:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic        m1_readdatavalid;
    logic [15:0] rd_data;
    logic [23:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic        s_waitrequest;
    logic [15:0] s_readdata;
    logic        s_readdatavalid;
    logic        err_orphan;

    int total = 0;
    int bad   = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    bit          acc_log[$];
    bit          pv[3];
    logic [15:0] pd[3];
    int          rcv0 = 0;
    int          rcv1 = 0;
    bit          pat[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .rd_data          (rd_data),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .err_orphan       (err_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // One cycle of the auto slave: returns data 3-4 cycles after accept.
    task automatic auto_cycle();
        logic        a0;
        logic        a1;
        logic [15:0] d;
        logic [15:0] e;
        @(negedge clk);
        a0 = m0_read && !m0_waitrequest;
        a1 = m1_read && !m1_waitrequest;
        d  = s_address[15:0] ^ 16'h5A5A;
        if (m0_readdatavalid) begin
            rcv0++;
            if (q0.size() == 0) chk("rt0_spurious", 1, 0);
            else begin
                e = q0.pop_front();
                chk("rt0_data", rd_data, e);
            end
        end
        if (m1_readdatavalid) begin
            rcv1++;
            if (q1.size() == 0) chk("rt1_spurious", 1, 0);
            else begin
                e = q1.pop_front();
                chk("rt1_data", rd_data, e);
            end
        end
        if (a0) q0.push_back(d);
        if (a1) q1.push_back(d);
        if (a0 || a1) acc_log.push_back(a1);
        @(posedge clk);
        #1;
        s_readdatavalid = pv[2];
        s_readdata      = pd[2];
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = a0 | a1; pd[0] = d;
        if (a0) m0_address = m0_address + 24'd1;
        if (a1) m1_address = m1_address + 24'd1;
        if (acc_log.size() >= 10) begin
            m0_read = 1'b0;
            m1_read = 1'b0;
        end
    endtask

    initial begin
        int cyc;
        int n;
        rst_n           = 1'b0;
        m0_address      = '0;
        m0_read         = 1'b0;
        m1_address      = '0;
        m1_read         = 1'b0;
        m1_write        = 1'b0;
        m1_writedata    = '0;
        m1_byteenable   = 2'b00;
        s_waitrequest   = 1'b0;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end

        mid();
        chk("rst_sread", s_read, 0);
        chk("rst_swrite", s_write, 0);
        chk("rst_saddr", s_address, 0);
        chk("rst_m0wait", m0_waitrequest, 1);
        chk("rst_m1wait", m1_waitrequest, 1);
        chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        chk("rst_err", err_orphan, 0);
        tick();
        rst_n = 1'b1;
        mid();
        chk("post_rst_m0wait", m0_waitrequest, 1);
        chk("post_rst_sbe", s_byteenable, 0);

        // Single CPU write
        tick();
        m1_address    = 24'h000010;
        m1_writedata  = 16'hBEEF;
        m1_byteenable = 2'b11;
        m1_write      = 1'b1;
        mid();
        chk("w_idle_swrite", s_write, 0);
        chk("w_idle_wait", m1_waitrequest, 1);
        tick();
        mid();
        chk("w_swrite", s_write, 1);
        chk("w_wdata", s_writedata, 16'hBEEF);
        chk("w_addr", s_address, 24'h000010);
        chk("w_be", s_byteenable, 2'b11);
        chk("w_wait", m1_waitrequest, 0);
        tick();
        m1_write = 1'b0;
        mid();
        chk("w_swrite_off", s_write, 0);
        tick();
        mid();
        chk("w_back_idle", m1_waitrequest, 1);

        // Streak pattern and read routing with both requesters reading
        tick();
        m0_address = 24'h000100;
        m1_address = 24'h000200;
        m0_read    = 1'b1;
        m1_read    = 1'b1;
        cyc = 0;
        for (int i = 0; i < 40 && acc_log.size() < 10; i++) begin
            auto_cycle();
            cyc++;
        end
        chk("arb_cycles", cyc, 11);
        for (int i = 0; i < 10; i++) begin
            if (i < acc_log.size()) chk("arb_pat", acc_log[i], pat[i]);
        end
        repeat (8) auto_cycle();
        chk("rt0_count", rcv0, 8);
        chk("rt1_count", rcv1, 2);
        chk("rt_left", q0.size() + q1.size(), 0);
        s_readdatavalid = 1'b0;

        // Controller stall during CPU read while video requests
        s_waitrequest = 1'b1;
        m1_address    = 24'h000123;
        m1_read       = 1'b1;
        mid();
        tick();
        m0_address = 24'h000777;
        m0_read    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("st_sread", s_read, 1);
            chk("st_addr", s_address, 24'h000123);
            chk("st_m0wait", m0_waitrequest, 1);
            chk("st_m1wait", m1_waitrequest, 1);
            tick();
        end
        s_waitrequest = 1'b0;
        mid();
        chk("st_accept", m1_waitrequest, 0);
        chk("st_addr_acc", s_address, 24'h000123);
        tick();
        m1_read = 1'b0;
        mid();
        chk("st_sw_addr", s_address, 24'h000777);
        chk("st_sw_wait", m0_waitrequest, 0);
        tick();
        m0_read         = 1'b0;
        s_readdatavalid = 1'b1;
        s_readdata      = 16'h1111;
        mid();
        chk("st_ret1_m1", m1_readdatavalid, 1);
        chk("st_ret1_m0", m0_readdatavalid, 0);
        chk("st_ret1_data", rd_data, 16'h1111);
        tick();
        s_readdata = 16'h2222;
        mid();
        chk("st_ret2_m0", m0_readdatavalid, 1);
        chk("st_ret2_m1", m1_readdatavalid, 0);
        tick();
        s_readdatavalid = 1'b0;

        // Fill the ID FIFO with CPU reads
        m1_address = 24'h000040;
        m1_read    = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 8; i++) begin
            mid();
            if (!m1_waitrequest) n++;
            tick();
        end
        chk("full_acc", n, 8);
        mid();
        chk("full_sread", s_read, 0);
        chk("full_wait", m1_waitrequest, 1);
        tick();
        m1_read      = 1'b0;
        m1_write     = 1'b1;
        m1_writedata = 16'hCAFE;
        mid();
        chk("full_swrite", s_write, 1);
        chk("full_wwait", m1_waitrequest, 0);
        tick();
        m1_write        = 1'b0;
        m1_read         = 1'b1;
        s_readdatavalid = 1'b1;
        s_readdata      = 16'h3333;
        mid();
        chk("full_still", s_read, 0);
        chk("full_rdv1", m1_readdatavalid, 1);
        tick();
        s_readdatavalid = 1'b0;
        mid();
        chk("full_free", s_read, 1);
        chk("full_acc9", m1_waitrequest, 0);
        tick();
        m1_read         = 1'b0;
        s_readdatavalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("drain_rdv1", m1_readdatavalid, 1);
            tick();
        end
        s_readdatavalid = 1'b0;

        // Orphan return
        mid();
        chk("orph_pre", err_orphan, 0);
        tick();
        s_readdatavalid = 1'b1;
        mid();
        chk("orph_rdv0", m0_readdatavalid, 0);
        chk("orph_rdv1", m1_readdatavalid, 0);
        tick();
        s_readdatavalid = 1'b0;
        mid();
        chk("orph_err", err_orphan, 1);

        // Asynchronous reset during a stalled read
        tick();
        s_waitrequest = 1'b1;
        m1_read       = 1'b1;
        mid();
        tick();
        mid();
        chk("rs_pre_sread", s_read, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_sread", s_read, 0);
        chk("rs_saddr", s_address, 0);
        chk("rs_m1wait", m1_waitrequest, 1);
        chk("rs_err", err_orphan, 0);
        m1_read       = 1'b0;
        s_waitrequest = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the single SDRAM controller slave port (the x16 SDRAM behind the sdram_wire pins).
- Requester 0: video/sprite fetch engine, read-only, latency-critical, so preferred.
- Requester 1: CPU-side bridge, read/write.
- Arbitrates commands, holds the grant stable through waitrequest, and tracks outstanding pipelined reads so each readdatavalid is routed to its issuer.

Parameters:
- ADDR_W, 24: word address width (16-bit words; 32 MB device).
- DATA_W, 16: data width.
- MAX_OUTSTANDING, 8: read-ID FIFO depth. Power of two, ≥2.
- M0_STREAK_MAX, 4: maximum consecutive accepted m0 commands while m1 is pending.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  requester 0 word address
- m0_read  in  1  requester 0 read request
- m0_waitrequest  out  1  requester 0 stall
- m0_readdatavalid  out  1  read data on rd_data belongs to requester 0
- m1_address  in  ADDR_W  requester 1 word address
- m1_read  in  1  requester 1 read request
- m1_write  in  1  requester 1 write request
- m1_writedata  in  DATA_W  requester 1 write data
- m1_byteenable  in  2  requester 1 byte enables
- m1_waitrequest  out  1  requester 1 stall
- m1_readdatavalid  out  1  read data on rd_data belongs to requester 1
- rd_data  out  DATA_W  s_readdata broadcast to both requesters, combinational
- s_address, s_read, s_write, s_writedata, s_byteenable  out  ADDR_W/1/1/DATA_W/2  command to SDRAM controller
- s_waitrequest  in  1  controller stall
- s_readdata  in  DATA_W  controller read data
- s_readdatavalid  in  1  controller read data valid
- err_orphan  out  1  sticky: readdatavalid arrived with the ID FIFO empty

Behaviour:
- Reset (async assert, sync deassert): state IDLE, streak 0, FIFO empty, err_orphan 0.
- Outputs during and immediately after reset: all s_* outputs 0; both waitrequests 1; both readdatavalids 0.
- States:
  - IDLE: no owner; all s_* command outputs 0; both waitrequests 1.
  - OWN0: m0 owns the slave port. m0 command forwarded combinationally; s_byteenable=2'b11, s_write=0.
  - OWN1: m1 owns the slave port. m1 command forwarded combinationally.
- Non-owner waitrequest is always 1. Owner waitrequest = s_waitrequest OR block_read.
- Accept = owner request asserted AND s_waitrequest=0 AND NOT block_read.
- block_read = forwarded read AND FIFO count==MAX_OUTSTANDING. While blocked, s_read is forced 0. Writes are never blocked.
- Grant latency: IDLE→OWNx takes one cycle.
  - IDLE with m0_read asserted goes to OWN0 (m0 wins ties); otherwise any m1 request goes to OWN1.
- Owner switches only on an accept cycle or when the owner's request is low. The grant never changes while a command is stalled.
- OWN0 on accept:
  - streak+1.
  - If m1 is requesting and streak+1≥M0_STREAK_MAX: go to OWN1, streak←0.
  - Otherwise stay in OWN0.
- OWN1 on accept: if m0_read is asserted, go to OWN0 with streak←0; otherwise stay in OWN1.
- Owner request low: switch to the other requester if it is requesting (streak←0); otherwise go to IDLE.
- Read-ID FIFO:
  - Push owner ID on an accepted read.
  - Pop on s_readdatavalid.
  - m0/m1_readdatavalid = s_readdatavalid AND (head==0 / head==1). Zero-latency routing.
  - Simultaneous push and pop is legal and leaves the count unchanged.
  - s_readdatavalid with the FIFO empty: no readdatavalid to either requester; set err_orphan (cleared only by reset).
- Count width is clog2(MAX_OUTSTANDING)+1. Pointers wrap modulo MAX_OUTSTANDING.

Decomposition:
- Shared package holds:
  - owner/state enum (IDLE, OWN0, OWN1);
  - requester ID constants (ID_VIDEO=0, ID_CPU=1);
  - SDRAM ADDR_W/DATA_W defaults.
- Sub-module rd_id_fifo: 1-bit wide, MAX_OUTSTANDING deep, with push, pop, head, count, empty, full.

Test Plan:
- Single m1 write, addr 0x000010, data 0xBEEF, s_waitrequest low → IDLE→OWN1 in 1 cycle, s_write high for 1 cycle with 0xBEEF, then back to IDLE.
- m0 and m1 both reading continuously, no stalls, M0_STREAK_MAX=4 → accept pattern 0,0,0,0,1,0,0,0,0,1.
- Controller returns readdatavalid 3 cycles after each accept, interleaved m0/m1 reads → each requester receives exactly its data, in order, with no misrouting.
- s_waitrequest held for 5 cycles during an m1 read while m0 requests → s_read and s_address stay stable, and OWN1 holds until accept.
- 8 reads accepted with no returns (MAX_OUTSTANDING=8) → 9th read is stalled with s_read=0 and the m1 write still passes; one return frees a slot and the next read is accepted.
- s_readdatavalid with FIFO empty → err_orphan=1, no readdatavalid. reset_reset_n pulsed mid-stall → all outputs return to reset values asynchronously.
